// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: IR fields and ALU flags toward the controller, datapath controls back (mem_ready only with MEM_WAIT_EN)
interface multicycle_control_unit_if #(
  parameter int ALUCTRL_W = 3,
  parameter int IMMSRC_W  = 3
);
  logic [6:0]           op;
  logic [2:0]           funct3;
  logic                 funct7b5;
  logic                 zero;
  logic                 lt;
`ifdef MEM_WAIT_EN
  logic                 mem_ready;
`endif
  logic                 PCWrite;
  logic                 AdrSrc;
  logic                 MemWrite;
  logic                 IRWrite;
  logic [1:0]           ResultSrc;
  logic [1:0]           ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic                 RegWrite;
  logic [IMMSRC_W-1:0]  ImmSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic                 illegal_instr;
`ifdef MEM_WAIT_EN
  modport master (
    input  op, funct3, funct7b5, zero, lt, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ImmSrc, ALUControl, illegal_instr
  );
  modport slave (
    output op, funct3, funct7b5, zero, lt, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ImmSrc, ALUControl, illegal_instr
  );
`else
  modport master (
    input  op, funct3, funct7b5, zero, lt,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ImmSrc, ALUControl, illegal_instr
  );
  modport slave (
    output op, funct3, funct7b5, zero, lt,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ImmSrc, ALUControl, illegal_instr
  );
`endif
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FSM controller for the multicycle RV32I datapath; MEM_WAIT_EN adds mem_ready wait states
module multicycle_control_unit #(
  parameter int ALUCTRL_W = 3,
  parameter int IMMSRC_W  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_control_unit_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL
  } state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_FUNC} alu_op_t;
  state_t  state, next;
  alu_op_t alu_op;
  logic    ready, taken;
  logic [2:0] alu_func, alu3, imm3;
`ifdef MEM_WAIT_EN
  assign ready = bus.mem_ready;
`else
  assign ready = 1'b1;
`endif
  // state register; reset aborts any instruction and returns to FETCH
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH;
    else        state <= next;
  // branch condition from funct3; unsupported encodings simply fall through
  always_comb begin
    taken = 1'b0;
    case (bus.funct3)
      3'b000:  taken = bus.zero;
      3'b001:  taken = !bus.zero;
      3'b100:  taken = bus.lt;
      3'b101:  taken = !bus.lt;
      default: taken = 1'b0;
    endcase
  end
  // ALU function decode from IR fields, then selection by ALUOp
  always_comb begin
    alu_func = bus.funct3 == 3'b000 ? {2'b00, bus.op[5] & bus.funct7b5} :
               bus.funct3 == 3'b010 ? 3'b101 :
               bus.funct3 == 3'b110 ? 3'b011 :
               bus.funct3 == 3'b111 ? 3'b010 : 3'b000;
    alu3 = alu_op == OP_SUB ? 3'b001 : alu_op == OP_FUNC ? alu_func : 3'b000;
    imm3 = bus.op == 7'b0100011 ? 3'b001 :
           bus.op == 7'b1100011 ? 3'b010 :
           bus.op == 7'b1101111 ? 3'b011 : 3'b000;
    bus.ALUControl = ALUCTRL_W'(alu3);
    bus.ImmSrc     = IMMSRC_W'(imm3);
  end
  // next state and per-state datapath controls
  always_comb begin
    next              = state;
    alu_op            = OP_ADD;
    bus.PCWrite       = 1'b0;
    bus.AdrSrc        = 1'b0;
    bus.MemWrite      = 1'b0;
    bus.IRWrite       = 1'b0;
    bus.ResultSrc     = 2'b00;
    bus.ALUSrcA       = 2'b00;
    bus.ALUSrcB       = 2'b00;
    bus.RegWrite      = 1'b0;
    bus.illegal_instr = 1'b0;
    case (state)
      FETCH: begin
        bus.IRWrite   = ready;
        bus.PCWrite   = ready;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        next          = ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        case (bus.op)
          7'b0000011, 7'b0100011: next = MEMADR;
          7'b0110011:             next = EXECUTER;
          7'b0010011:             next = EXECUTEI;
          7'b1100011:             next = BRANCH;
          7'b1101111:             next = JAL;
          default: begin
            next              = FETCH;
            bus.illegal_instr = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        next        = bus.op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        bus.AdrSrc = 1'b1;
        next       = ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = 1'b1;
        next          = FETCH;
      end
      MEMWRITE: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = ready;
        next         = ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        bus.ALUSrcA = 2'b10;
        alu_op      = OP_FUNC;
        next        = ALUWB;
      end
      EXECUTEI: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        alu_op      = OP_FUNC;
        next        = ALUWB;
      end
      ALUWB: begin
        bus.RegWrite = 1'b1;
        next         = FETCH;
      end
      BRANCH: begin
        bus.ALUSrcA = 2'b10;
        alu_op      = OP_SUB;
        bus.PCWrite = taken;
        next        = FETCH;
      end
      JAL: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.PCWrite = 1'b1;
        next        = ALUWB;
      end
      default: next = FETCH;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed and random instructions checked against a per-instruction timeline model
module tb_multicycle_control_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [17:0] exp_q[$];
  multicycle_control_unit_if #(.ALUCTRL_W(3), .IMMSRC_W(3)) bus();
  multicycle_control_unit #(.ALUCTRL_W(3), .IMMSRC_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // output snapshot: {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,RegWrite,ImmSrc,ALUControl,illegal}
  function automatic logic [17:0] observed();
    return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc, bus.ALUSrcA,
            bus.ALUSrcB, bus.RegWrite, bus.ImmSrc, bus.ALUControl, bus.illegal_instr};
  endfunction
  function automatic logic [2:0] imm_of(input logic [6:0] o);
    return o == 7'b0100011 ? 3'd1 : o == 7'b1100011 ? 3'd2 : o == 7'b1101111 ? 3'd3 : 3'd0;
  endfunction
  function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'd1 : 3'd0;
      3'b010:  return 3'd5;
      3'b110:  return 3'd3;
      3'b111:  return 3'd2;
      default: return 3'd0;
    endcase
  endfunction
  function automatic logic taken_of(input logic [2:0] f3, input logic z, input logic l);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return l;
      3'b101:  return !l;
      default: return 1'b0;
    endcase
  endfunction
  function automatic logic [17:0] mk(input logic pcw, adr, mw, irw, input logic [1:0] rs, sa, sb,
                                     input logic rw, input logic [2:0] alu, input logic ill, input logic [6:0] o);
    return {pcw, adr, mw, irw, rs, sa, sb, rw, imm_of(o), alu, ill};
  endfunction
  // expected cycle-by-cycle controls for one whole instruction
  task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7, z, l);
    logic legal;
    legal = o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    exp_q = {};
    exp_q.push_back(mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, 3'd0, 0, o));
    exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 3'd0, !legal, o));
    if (o == 7'b0000011 || o == 7'b0100011)
      exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'd0, 0, o));
    if (o == 7'b0000011) begin
      exp_q.push_back(mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'd0, 0, o));
      exp_q.push_back(mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 3'd0, 0, o));
    end
    if (o == 7'b0100011)
      exp_q.push_back(mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 3'd0, 0, o));
    if (o == 7'b0110011 || o == 7'b0010011)
      exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, o[5] ? 2'b00 : 2'b01, 0, alu_of(o, f3, f7), 0, o));
    if (o == 7'b1100011)
      exp_q.push_back(mk(taken_of(f3, z, l), 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'd1, 0, o));
    if (o == 7'b1101111)
      exp_q.push_back(mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 3'd0, 0, o));
    if (o == 7'b0110011 || o == 7'b0010011 || o == 7'b1101111)
      exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'd0, 0, o));
  endtask
  task automatic chk(input string tag, input int step, input logic [17:0] got, input logic [17:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s step %0d: got %h expected %h", tag, step, got, exp);
    end
  endtask
  // entered in the first FETCH cycle between negedge and posedge; leaves at the next instruction's FETCH
  task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3, input logic f7, z, l);
    bus.op = o;
    bus.funct3 = f3;
    bus.funct7b5 = f7;
    bus.zero = z;
    bus.lt = l;
    build(o, f3, f7, z, l);
    foreach (exp_q[i]) begin
      #1;
      chk(tag, i, observed(), exp_q[i]);
      @(negedge clk);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    logic [6:0] pool[6];
    logic [6:0] o;
    pool = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    bus.op = 7'b0;
    bus.funct3 = 3'b0;
    bus.funct7b5 = 1'b0;
    bus.zero = 1'b0;
    bus.lt = 1'b0;
`ifdef MEM_WAIT_EN
    bus.mem_ready = 1'b1;
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("reset_fetch", 0, observed(), mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, 3'd0, 0, 7'b0));
    @(negedge clk);
    rst_n = 1'b1;
    run_instr("lw", 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
    run_instr("sub", 7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0);
    run_instr("add", 7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0);
    run_instr("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0);
    run_instr("bne_nz", 7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0);
    run_instr("beq_nz", 7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0);
    run_instr("bge_lt", 7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1);
    run_instr("blt_lt", 7'b1100011, 3'b100, 1'b0, 1'b1, 1'b1);
    run_instr("br_010", 7'b1100011, 3'b010, 1'b0, 1'b1, 1'b1);
    run_instr("illegal", 7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0);
    run_instr("sw", 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
    run_instr("jal", 7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0);
    run_instr("slt", 7'b0110011, 3'b010, 1'b0, 1'b0, 1'b0);
    run_instr("or", 7'b0110011, 3'b110, 1'b0, 1'b0, 1'b0);
    run_instr("andi", 7'b0010011, 3'b111, 1'b0, 1'b0, 1'b0);
    // reset asserted during lw write-back must drop RegWrite immediately
    bus.op = 7'b0000011;
    repeat (4) @(negedge clk);
    #1;
    chk("midrst_pre", 0, {17'b0, bus.RegWrite}, 18'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_post", 0, observed(), mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, 3'd0, 0, 7'b0000011));
    @(negedge clk);
    rst_n = 1'b1;
    run_instr("after_rst", 7'b0010011, 3'b110, 1'b0, 1'b0, 1'b0);
`ifdef MEM_WAIT_EN
    // sw stalled two cycles in MEMWRITE
    bus.op = 7'b0100011;
    repeat (3) @(negedge clk);
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("wait_mw_low", k, {17'b0, bus.MemWrite}, 18'd0);
      @(negedge clk);
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("wait_mw_high", 0, {17'b0, bus.MemWrite}, 18'd1);
    @(negedge clk);
    #1;
    chk("wait_fetch", 0, {17'b0, bus.IRWrite}, 18'd1);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
`endif
    for (int n = 0; n < 150; n++) begin
      o = ($urandom_range(0, 7) == 0) ? 7'($urandom) : pool[$urandom_range(0, 5)];
      run_instr("rand", o, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- FSM-based controller for the multicycle RV32I datapath (shared instruction/data memory, IR/OldPC/Data/ALUOut registers).
- Sequences FETCH/DECODE/EXECUTE/MEM/WB over 3–5 cycles per instruction.
- Generalises branch handling to beq/bne/blt/bge and parametrises ALUControl/ImmSrc widths.
- Sits between the instruction register (op, funct3, funct7b5) and the datapath muxes/enables.

Parameters:
- ALUCTRL_W, 3, ALUControl width; must be ≥3; bits above [2:0] driven 0.
- IMMSRC_W, 3, ImmSrc width; must be ≥2; unused upper bits driven 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  7  instruction opcode (IR[6:0]).
- funct3  in  3  IR[14:12].
- funct7b5  in  1  IR[30].
- zero  in  1  ALU result == 0.
- lt  in  1  ALU signed less-than flag (SrcA < SrcB).
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- MemWrite  out  1  memory write enable.
- IRWrite  out  1  IR/OldPC load enable.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rd1.
- ALUSrcB  out  2  00 = rd2, 01 = ImmExt, 10 = constant 4.
- RegWrite  out  1  register file write enable.
- ImmSrc  out  IMMSRC_W  000 = I, 001 = S, 010 = B, 011 = J; combinational from op.
- ALUControl  out  ALUCTRL_W  000 add, 001 sub, 010 and, 011 or, 101 slt.
- illegal_instr  out  1  one-cycle pulse on unsupported opcode.

Behaviour:
- Reset (rst_n = 0, asynchronous): state = FETCH. All registered flags cleared; illegal_instr = 0.
- Outputs are Moore (decoded from state), except:
  - PCWrite in BRANCH (depends on taken).
  - ImmSrc and ALUControl (also depend on IR fields).
- Per-state outputs (unlisted enables = 0; unlisted selects = 00):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcB=10, ALUOp=add, ResultSrc=10, PCWrite=1 → DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=add. Next state by op:
    - 0000011 / 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - other → FETCH, with illegal_instr=1 for that cycle.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add → MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00 → MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 → FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=func → ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=func → ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, PCWrite=taken → FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 → ALUWB.
- Branch taken rule:
  - funct3 000: zero
  - funct3 001: !zero
  - funct3 100: lt
  - funct3 101: !lt
  - any other funct3: not taken (no trap).
- ALU decode:
  - ALUOp add → 000; sub → 001.
  - ALUOp func:
    - funct3 000 → sub if (op[5] & funct7b5), else add.
    - funct3 010 → slt; 110 → or; 111 → and.
    - others → add.
- Cycle counts: lw 5; sw 4; R/I 4; branch 3; jal 4.
- Reset asserted mid-instruction aborts it; no MemWrite/RegWrite is asserted after the asynchronous assertion of rst_n.
- At most one of MemWrite/RegWrite is high in any cycle. IRWrite is high only in FETCH.

Optional Feature:
- Macro: MEM_WAIT_EN.
- When defined:
  - Adds input mem_ready (1 bit).
  - FETCH, MEMREAD and MEMWRITE hold their state while mem_ready=0.
  - IRWrite/PCWrite/MemWrite are asserted only in the cycle mem_ready=1; selects stay stable while waiting.
  - Reset during a wait returns to FETCH.
- When undefined: memory is assumed single-cycle; no mem_ready port; timing exactly as above.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release → state FETCH; first cycle shows IRWrite=1, PCWrite=1, ALUSrcB=10, MemWrite=0, RegWrite=0.
- lw: op=0000011 → 5-cycle sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5 with ResultSrc=01.
- sub R-type: op=0110011, funct3=000, funct7b5=1 → ALUControl=001 in EXECUTER; RegWrite in cycle 4. With funct7b5=0 → 000.
- Branches with op=1100011:
  - bne with zero=0 → PCWrite=1 in cycle 3.
  - beq with zero=0 → PCWrite=0.
  - bge with lt=1 → PCWrite=0.
  - funct3=010 → PCWrite=0.
- Illegal opcode: op=0110111 → illegal_instr=1 in DECODE cycle, next state FETCH, no RegWrite/MemWrite.
- Wait states (MEM_WAIT_EN): sw with mem_ready=0 for 2 cycles in MEMWRITE → MemWrite=0 while waiting, 1 for exactly one cycle when mem_ready=1, then FETCH.
